spi_frame_rx: RTL and testbench



---
 rtl/doppler_spi_pkg.sv | 7 +
 rtl/edge_sync.sv | 30 +++
 rtl/spi_frame_rx.sv | 111 +++++++++++
 tb/tb_spi_frame_rx.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/doppler_spi_pkg.sv
// Shared constants and types for the Doppler config-SPI receive path.
package doppler_spi_pkg;
    localparam int   SPI_FRAME_BITS = 16;
    localparam logic SPI_MISO_IDLE  = 1'b1;

    typedef enum logic {IDLE, ACTIVE} spi_state_t;
endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for one asynchronous pin, plus rise/fall detect
// against one extra flop behind the last stage.
module edge_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave front end: synchronises SCK/CS/MOSI into clk, assembles
// fixed-length MSB-first frames and returns a preloaded word on MISO.
module spi_frame_rx
    import doppler_spi_pkg::*;
#(
    parameter int FRAME_BITS  = SPI_FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sck,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_error,
    output logic                  busy
);
    localparam int CW    = $clog2(FRAME_BITS + 2);
    localparam int FLUSH = SYNC_STAGES + 1;
    localparam int FW    = $clog2(FLUSH + 1);

    logic sck_level, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_sync, unused_mosi_rise, unused_mosi_fall;

    edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst(rst), .din(spi_sck),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );
    edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst(rst), .din(spi_cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );
    edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .din(spi_mosi),
        .level(mosi_sync), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    spi_state_t            state, nstate;
    logic [FRAME_BITS-1:0] tx_shift, rx_shift;
    logic [CW-1:0]         bit_cnt;
    logic [FW-1:0]         flush_cnt;
    logic                  flush_done, armed, start;

    // The CS chain resets high, so a CS already low at reset release looks
    // like a fall once the chain flushes; only arm after CS is seen high.
    assign flush_done = (flush_cnt == FW'(FLUSH));
    assign start      = cs_fall & armed;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start)   nstate = ACTIVE;
            ACTIVE:  if (cs_rise) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == ACTIVE);
        spi_miso = busy ? tx_shift[FRAME_BITS-1] : SPI_MISO_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift  <= '1;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_error  <= 1'b0;
            flush_cnt <= '0;
            armed     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            if (!flush_done)            flush_cnt <= flush_cnt + 1'b1;
            if (flush_done && cs_level) armed     <= 1'b1;

            if (state == IDLE) begin
                if (start) begin
                    tx_shift <= tx_data;
                    rx_shift <= '0;
                    bit_cnt  <= '0;
                end
            end else if (cs_rise) begin
                // CS edge wins over any SCK edge detected in the same cycle
                if (bit_cnt == CW'(FRAME_BITS)) begin
                    rx_data  <= rx_shift;
                    rx_valid <= 1'b1;
                end else begin
                    rx_error <= 1'b1;
                end
            end else begin
                if (sck_rise) begin
                    rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_sync};
                    if (bit_cnt != CW'(FRAME_BITS + 1)) bit_cnt <= bit_cnt + 1'b1;
                end
                if (sck_fall) tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b1};
            end
        end
    end
endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench for spi_frame_rx: stimulus pushes expected strobes,
// a negedge monitor pops and compares them when rx_valid/rx_error fire.
module tb_spi_frame_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic        spi_miso;
    logic [15:0] tx_data = '0;
    logic [15:0] rx_data;
    logic        rx_valid, rx_error, busy;

    typedef struct {
        logic        is_err;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    spi_frame_rx #(.FRAME_BITS(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .tx_data(tx_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error), .busy(busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_err, input logic [15:0] data);
        exp_t e;
        e.is_err = is_err;
        e.data   = data;
        exp_q.push_back(e);
    endtask

    // CS low, then n mode-0 bits MSB first; CS is left low. SCK half = 24 clk.
    task automatic send_bits(input logic [31:0] data, input int n, output logic [31:0] mbits);
        mbits    = '0;
        spi_cs_n = 1'b0;
        wait_clk(24);
        for (int i = 0; i < n; i++) begin
            spi_mosi = data[n-1-i];
            wait_clk(24);
            mbits   = {mbits[30:0], spi_miso};
            spi_sck = 1'b1;
            wait_clk(24);
            spi_sck = 1'b0;
        end
        wait_clk(24);
    endtask

    task automatic cs_release();
        spi_cs_n = 1'b1;
        wait_clk(30);
    endtask

    always @(negedge clk) begin
        if (!rst && (rx_valid || rx_error)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected strobe: valid=%b error=%b rx_data=%h, expected none",
                         rx_valid, rx_error, rx_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe rx_error", {31'd0, rx_error}, {31'd0, e.is_err});
                chk("strobe rx_valid", {31'd0, rx_valid}, {31'd0, ~e.is_err});
                chk("strobe rx_data", {16'd0, rx_data}, {16'd0, e.data});
            end
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] mb;

        // reset state
        wait_clk(3);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset miso", {31'd0, spi_miso}, 32'd1);
        chk("reset rx_data", {16'd0, rx_data}, 32'd0);
        chk("reset strobes", {30'd0, rx_valid, rx_error}, 32'd0);
        rst = 1'b0;
        wait_clk(10);

        // 1: good frame, MISO returns tx_data
        tx_data = 16'h53F0;
        send_bits(32'h0000A5C3, 16, mb);
        chk("t1 miso word", mb, 32'h000053F0);
        push(1'b0, 16'hA5C3);
        cs_release();

        // 2: short and long frames
        send_bits(32'h00000ABC, 12, mb);
        push(1'b1, 16'hA5C3);
        cs_release();
        send_bits(32'h0001FFFF, 17, mb);
        push(1'b1, 16'hA5C3);
        cs_release();

        // 3: stray SCK while CS high, then good frame
        for (int i = 0; i < 4; i++) begin
            spi_sck = 1'b1; wait_clk(8);
            spi_sck = 1'b0; wait_clk(8);
        end
        send_bits(32'h00000001, 16, mb);
        push(1'b0, 16'h0001);
        cs_release();

        // 4: reset mid-frame
        send_bits(32'h000000FF, 8, mb);
        rst = 1'b1;
        wait_clk(1);
        chk("t4 busy after rst", {31'd0, busy}, 32'd0);
        chk("t4 rx_data after rst", {16'd0, rx_data}, 32'd0);
        rst = 1'b0;
        wait_clk(10);
        cs_release();
        send_bits(32'h0000FFFF, 16, mb);
        push(1'b0, 16'hFFFF);
        cs_release();

        // 5: CS held low across reset release
        spi_cs_n = 1'b0;
        wait_clk(5);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        send_bits(32'h0000BEEF, 16, mb);
        chk("t5 busy while unarmed", {31'd0, busy}, 32'd0);
        cs_release();
        send_bits(32'h00001234, 16, mb);
        push(1'b0, 16'h1234);
        cs_release();

        // 6: CS rise coincident with the 16th SCK rise
        chk("t6 idle miso", {31'd0, spi_miso}, 32'd1);
        send_bits(32'h00007FFF, 15, mb);
        spi_mosi = 1'b1;
        wait_clk(24);
        push(1'b1, 16'h1234);
        spi_sck  = 1'b1;
        spi_cs_n = 1'b1;
        wait_clk(24);
        spi_sck = 1'b0;
        wait_clk(24);
        chk("t6 idle miso after frame", {31'd0, spi_miso}, 32'd1);

        tx_data = 16'h0F0F;
        send_bits(32'h00005A5A, 16, mb);
        chk("t6 miso word", mb, 32'h00000F0F);
        chk("t6 busy", {31'd0, busy}, 32'd1);
        chk("t6 miso after 16 shifts", {31'd0, spi_miso}, 32'd1);
        push(1'b0, 16'h5A5A);
        cs_release();

        wait_clk(50);
        chk("pending expected strobes", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
